// File: rtl/stereo_pan_mixer.sv
// stereo_pan_mixer: splits a signed mono sample into left/right channels
// using linear pan gains and one shared serial shift-add multiplier
// (15 iterations + 1 latch cycle per channel, LSB first).
// Optional build macro: PAN_SMOOTH_EN -- slew-limits the effective pan by
// at most PAN_STEP per accepted sample, starting from centre (0x4000).
module stereo_pan_mixer #(
  parameter int          SAMPLE_W = 16,
  parameter logic [15:0] PAN_STEP = 16'h0040
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic        [15:0]         pan,
  output logic                       busy,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] left_out,
  output logic signed [SAMPLE_W-1:0] right_out,
  output logic                       overrun
);

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, DONE} state_t;

`ifdef PAN_SMOOTH_EN
  localparam logic [14:0] PAN_RST = 15'h4000;
`else
  localparam logic [14:0] PAN_RST = 15'h0000;
`endif

  state_t                       state_reg, state_next;
  logic                         accept;
  logic                         last_iter;
  logic [3:0]                   cnt_reg;
  logic signed [SAMPLE_W-1:0]   sample_reg;
  logic signed [SAMPLE_W-1:0]   acc_reg;
  logic signed [SAMPLE_W-1:0]   addend;
  logic signed [SAMPLE_W-1:0]   left_res_reg;
  logic signed [SAMPLE_W-1:0]   right_res_reg;
  logic [14:0]                  gain_sr_reg;
  logic [14:0]                  pan_eff_reg;
  logic [14:0]                  pan_eff_next;
  logic [14:0]                  pan_clamped;

  // A negative pan word means "beyond full right"; pin it there.
  assign pan_clamped = pan[15] ? 15'h7FFF : pan[14:0];
  assign last_iter   = (cnt_reg == 4'd15);
  assign busy        = (state_reg != IDLE);
  assign addend      = gain_sr_reg[0] ? sample_reg : '0;

  // Effective pan for the sample being accepted this cycle.
  always_comb begin
    pan_eff_next = pan_clamped;
`ifdef PAN_SMOOTH_EN
    if (pan_clamped > pan_eff_reg) begin
      if ({1'b0, pan_clamped - pan_eff_reg} > PAN_STEP)
        pan_eff_next = pan_eff_reg + PAN_STEP[14:0];
    end else begin
      if ({1'b0, pan_eff_reg - pan_clamped} > PAN_STEP)
        pan_eff_next = pan_eff_reg - PAN_STEP[14:0];
    end
`endif
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; accept only from IDLE so late strobes are dropped.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE:    if (in_valid) begin
                 accept     = 1'b1;
                 state_next = MUL_L;
               end
      MUL_L:   if (last_iter) state_next = MUL_R;
      MUL_R:   if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, serial multiply, result latching and output update.
  // The accumulator holds the running product already shifted right, so each
  // iteration adds the sample (if the gain bit is set) and halves with an
  // arithmetic shift; after 15 steps it equals floor(sample*gain / 2^15).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg       <= '0;
      sample_reg    <= '0;
      acc_reg       <= '0;
      left_res_reg  <= '0;
      right_res_reg <= '0;
      gain_sr_reg   <= '0;
      pan_eff_reg   <= PAN_RST;
      out_valid     <= 1'b0;
      left_out      <= '0;
      right_out     <= '0;
      overrun       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && state_reg != IDLE)
        overrun <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            sample_reg  <= sample_in;
            pan_eff_reg <= pan_eff_next;
            gain_sr_reg <= 15'h7FFF - pan_eff_next;
            acc_reg     <= '0;
            cnt_reg     <= '0;
          end
        end
        MUL_L, MUL_R: begin
          if (!last_iter) begin
            acc_reg <= SAMPLE_W'(($signed({acc_reg[SAMPLE_W-1], acc_reg})
                                 + $signed({addend[SAMPLE_W-1], addend})) >>> 1);
            gain_sr_reg <= gain_sr_reg >> 1;
            cnt_reg     <= cnt_reg + 4'd1;
          end else begin
            cnt_reg <= '0;
            acc_reg <= '0;
            if (state_reg == MUL_L) begin
              left_res_reg <= acc_reg;
              gain_sr_reg  <= pan_eff_reg;
            end else begin
              right_res_reg <= acc_reg;
            end
          end
        end
        DONE: begin
          left_out  <= left_res_reg;
          right_out <= right_res_reg;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
